farbfeld_loader: RTL

Sequencing controller for the farbfeld stream parser.
- Pulls image bytes from a valid/ready byte source and presents them to the parser as a stable data byte plus a one-cycle ready strobe.
- Snoops the 16-byte header for magic and dimensions.
- Writes each completed pixel into the monitor framebuffer, stalling under write backpressure, and reports done/error.

---
 rtl/farbfeld_pkg.sv | 29 ++
 rtl/farbfeld_byte_strober.sv | 65 ++++++
 rtl/farbfeld_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/farbfeld_pkg.sv
// Shared constants and state encodings for the farbfeld loader and its byte strober.
package farbfeld_pkg;

    localparam int HDR_LEN         = 16;
    localparam int BYTES_PER_PIXEL = 8;

    localparam logic [7:0] MAGIC [8] = '{8'h66, 8'h61, 8'h72, 8'h62, 8'h66, 8'h65, 8'h6C, 8'h64};

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MAGIC = 2'd1,
        ERR_SIZE  = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERR
    } ctl_state_e;

    typedef enum logic [1:0] {
        FETCH,
        SETUP,
        STROBE,
        GAP
    } strb_state_e;

endpackage

// File: rtl/farbfeld_byte_strober.sv
// Moves one source byte at a time to the parser: latch, settle, one-cycle strobe, gap.
// Rests in GAP; hold keeps it there so the controller decides when the next fetch starts.
module farbfeld_byte_strober
    import farbfeld_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       src_valid_i,
    input  logic [7:0] src_data_i,
    output logic       src_ready_o,
    output logic [7:0] ff_data_o,
    output logic       ff_ready_o,
    output logic       byte_accepted_o
);

    strb_state_e state_q;
    logic        src_ready_q;
    logic [7:0]  ff_data_q;
    logic        ff_ready_q;

    assign src_ready_o     = src_ready_q;
    assign ff_data_o       = ff_data_q;
    assign ff_ready_o      = ff_ready_q;
    assign byte_accepted_o = src_valid_i & src_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= GAP;
            src_ready_q <= 1'b0;
            ff_data_q   <= 8'h00;
            ff_ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (src_valid_i) begin
                        ff_data_q   <= src_data_i;
                        src_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    ff_ready_q <= 1'b1;
                    state_q    <= STROBE;
                end
                STROBE: begin
                    ff_ready_q <= 1'b0;
                    state_q    <= GAP;
                end
                GAP: begin
                    if (!hold_i) begin
                        src_ready_q <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    src_ready_q <= 1'b0;
                    ff_ready_q  <= 1'b0;
                    state_q     <= GAP;
                end
            endcase
        end
    end

endmodule

// File: rtl/farbfeld_loader.sv
// Farbfeld load controller: feeds the parser byte by byte, checks the header, and
// retires completed pixels into the monitor framebuffer through a one-entry pend slot.
module farbfeld_loader
    import farbfeld_pkg::*;
#(
    parameter int FB_W   = 640,
    parameter int FB_H   = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              src_valid_i,
    input  logic [7:0]        src_data_i,
    output logic              src_ready_o,
    output logic [7:0]        ff_data_o,
    output logic              ff_ready_o,
    input  logic [31:0]       ff_row_i,
    input  logic [31:0]       ff_col_i,
    input  logic [15:0]       ff_red_i,
    input  logic [15:0]       ff_green_i,
    input  logic [15:0]       ff_blue_i,
    input  logic              ff_pixelready_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [23:0]       fb_rgb_o,
    input  logic              fb_busy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        error_o
);

    ctl_state_e        state_q;
    logic [4:0]        hdr_cnt_q;
    logic              magic_bad_q;
    logic              hdr_last_q;
    logic              gap_q;
    logic              pix_prev_q;
    logic [31:0]       width_q;
    logic [31:0]       height_q;
    logic [31:0]       target_q;
    logic [31:0]       pix_cnt_q;
    logic              pend_q;
    logic              pend_drop_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [23:0]       fb_rgb_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        error_q;

    logic        byte_accepted;
    logic        hold;
    logic        pix_edge;
    logic        size_bad;
    logic        dim_zero;
    logic        hdr_exit;
    logic        in_range;
    logic        retire;
    logic [31:0] addr_full;
    logic        unused_lo;

    assign unused_lo = ^{ff_red_i[7:0], ff_green_i[7:0], ff_blue_i[7:0]};

    assign pix_edge  = ff_pixelready_i & ~pix_prev_q;
    assign size_bad  = (|width_q[31:16]) | (|height_q[31:16]);
    assign dim_zero  = (width_q == 32'd0) | (height_q == 32'd0);
    // gap_q marks the GAP cycle of the byte just strobed; header verdicts are taken there.
    assign hdr_exit  = gap_q & (magic_bad_q | (hdr_last_q & (size_bad | dim_zero)));
    assign in_range  = (ff_row_i < 32'(FB_H)) & (ff_col_i < 32'(FB_W));
    assign addr_full = ff_row_i * 32'(FB_W) + ff_col_i;
    assign retire    = pend_q & (pend_drop_q | ~fb_busy_i);
    // The edge term covers the cycle before pend fills, so no byte slips past a pixel.
    assign hold      = (state_q != RUN) | pend_q | pix_edge | hdr_exit;

    assign fb_we_o   = pend_q & ~pend_drop_q & ~fb_busy_i;
    assign fb_addr_o = fb_addr_q;
    assign fb_rgb_o  = fb_rgb_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;

    farbfeld_byte_strober u_strober (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hold_i          (hold),
        .src_valid_i     (src_valid_i),
        .src_data_i      (src_data_i),
        .src_ready_o     (src_ready_o),
        .ff_data_o       (ff_data_o),
        .ff_ready_o      (ff_ready_o),
        .byte_accepted_o (byte_accepted)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= 5'd0;
            magic_bad_q <= 1'b0;
            hdr_last_q  <= 1'b0;
            gap_q       <= 1'b0;
            pix_prev_q  <= 1'b0;
            width_q     <= 32'd0;
            height_q    <= 32'd0;
            target_q    <= 32'd0;
            pix_cnt_q   <= 32'd0;
            pend_q      <= 1'b0;
            pend_drop_q <= 1'b0;
            fb_addr_q   <= '0;
            fb_rgb_q    <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= ERR_NONE;
        end else begin
            pix_prev_q <= ff_pixelready_i;
            gap_q      <= ff_ready_o;
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= ERR_NONE;
                        hdr_cnt_q   <= 5'd0;
                        magic_bad_q <= 1'b0;
                        hdr_last_q  <= 1'b0;
                        width_q     <= 32'd0;
                        height_q    <= 32'd0;
                        target_q    <= 32'd0;
                        pix_cnt_q   <= 32'd0;
                        pend_q      <= 1'b0;
                        pend_drop_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (byte_accepted && (hdr_cnt_q < 5'(HDR_LEN))) begin
                        hdr_cnt_q <= hdr_cnt_q + 5'd1;
                        if (hdr_cnt_q < 5'd8) begin
                            if (src_data_i != MAGIC[hdr_cnt_q[2:0]])
                                magic_bad_q <= 1'b1;
                        end else if (hdr_cnt_q < 5'd12) begin
                            width_q <= {width_q[23:0], src_data_i};
                        end else begin
                            height_q <= {height_q[23:0], src_data_i};
                        end
                        if (hdr_cnt_q == 5'(HDR_LEN - 1))
                            hdr_last_q <= 1'b1;
                    end

                    if (hdr_exit) begin
                        busy_q     <= 1'b0;
                        hdr_last_q <= 1'b0;
                        if (magic_bad_q) begin
                            state_q <= ERR;
                            error_q <= ERR_MAGIC;
                        end else if (size_bad) begin
                            state_q <= ERR;
                            error_q <= ERR_SIZE;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (gap_q && hdr_last_q) begin
                        hdr_last_q <= 1'b0;
                        target_q   <= width_q * height_q;
                    end

                    if (pix_edge && !pend_q) begin
                        pend_q      <= 1'b1;
                        pend_drop_q <= ~in_range;
                        fb_addr_q   <= addr_full[ADDR_W-1:0];
                        fb_rgb_q    <= {ff_red_i[15:8], ff_green_i[15:8], ff_blue_i[15:8]};
                    end else if (retire) begin
                        pend_q    <= 1'b0;
                        pix_cnt_q <= pix_cnt_q + 32'd1;
                        if (pix_cnt_q + 32'd1 == target_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
